alu_issue_stage: RTL and testbench

Decode-to-execute issue stage that produces the control and operand bundle consumed by the EX-stage ALU (`ALUop[2:0]`, `funct[2:0]`, `invert`, `alu_in1`, `alu_in2`). It accepts one decoded RV32I instruction per cycle with register-file read data and PC, then builds ALU operands and control. The bundle is registered into a 2-entry skid buffer with valid/ready handshakes on both sides. The stage sits between ID and EX and supports pipeline flush.

---
 rtl/alu_ctrl_pkg.sv | 34 +++
 rtl/rv32_imm_gen.sv | 15 +
 rtl/alu_issue_stage.sv | 129 ++++++++++++
 tb/tb_alu_issue_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, ALU op classes and the issued bundle type
package alu_ctrl_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_SR   = 3'b101;
  typedef enum logic [2:0] {
    ALU_FUNCT = 3'b000,
    ALU_MEM   = 3'b001,
    ALU_ADD   = 3'b011,
    ALU_CSR   = 3'b100,
    ALU_SUB   = 3'b101
  } alu_op_e;
  typedef struct packed {
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    alu_op_e     alu_op;
    logic [2:0]  funct;
    logic        invert;
    logic [4:0]  rd;
    logic        reg_we;
    logic        illegal;
  } alu_bundle_t;
endpackage

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen: combinational RV32I immediate extraction
module rv32_imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I into an ALU control/operand bundle held in a 2-entry skid buffer
module alu_issue_stage
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [2:0]      ALUop,
  output logic [2:0]      funct,
  output logic            invert,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic            illegal
);
  alu_bundle_t dec, m_q, m_d, s_q, s_d;
  logic mv_q, mv_d, sv_q, sv_d, we, acc, m_load;
  logic [31:0] imm_i, imm_s, imm_u;
  logic [2:0] f3;
  rv32_imm_gen u_imm (
    .instr(instr), .imm_i(imm_i), .imm_s(imm_s), .imm_b(), .imm_u(imm_u), .imm_j()
  );
  assign f3 = instr[14:12];
  always_comb begin
    dec = '0;
    dec.rd = instr[11:7];
    dec.alu_in1 = rs1_data;
    dec.alu_in2 = rs2_data;
    we = 1'b1;
    case (instr[6:0])
      OPC_OP: begin
        dec.funct = f3;
        dec.invert = instr[30] && (f3 == F3_ADD || f3 == F3_SR);
        dec.alu_op = (instr[30] && f3 == F3_ADD) ? ALU_SUB : ALU_FUNCT;
      end
      OPC_OPIMM: begin
        dec.funct = f3;
        dec.invert = instr[30] && f3 == F3_SR;
        dec.alu_in2 = imm_i;
      end
      OPC_LOAD: begin
        dec.alu_op = ALU_MEM;
        dec.alu_in2 = imm_i;
      end
      OPC_STORE: begin
        dec.alu_op = ALU_MEM;
        dec.alu_in2 = imm_s;
        we = 1'b0;
      end
      // BEQ/BNE compare by subtraction; the ordered branches reuse SLT/SLTU
      OPC_BRANCH: begin
        we = 1'b0;
        dec.alu_op = f3[2] ? ALU_FUNCT : ALU_SUB;
        dec.invert = !f3[2];
        dec.funct = f3[2] ? (f3[1] ? F3_SLTU : F3_SLT) : F3_ADD;
      end
      OPC_LUI: begin
        dec.alu_op = ALU_ADD;
        dec.alu_in1 = '0;
        dec.alu_in2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.alu_op = ALU_ADD;
        dec.alu_in1 = pc;
        dec.alu_in2 = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        dec.alu_op = ALU_ADD;
        dec.alu_in1 = pc;
        dec.alu_in2 = 32'd4;
      end
      OPC_SYSTEM: begin
        dec.illegal = f3 == 3'b000;
        dec.alu_op = dec.illegal ? ALU_FUNCT : ALU_CSR;
        dec.funct = dec.illegal ? 3'b000 : f3;
        dec.alu_in1 = dec.illegal ? '0 : f3[2] ? {27'b0, instr[19:15]} : rs1_data;
        dec.alu_in2 = '0;
      end
      default: begin
        dec.illegal = 1'b1;
        dec.alu_in1 = '0;
        dec.alu_in2 = '0;
      end
    endcase
    dec.reg_we = we && !dec.illegal && |dec.rd;
  end
  assign acc = in_valid && in_ready;
  assign m_load = !mv_q || out_ready;
  always_comb begin
    mv_d = flush ? 1'b0 : m_load ? (sv_q || acc) : 1'b1;
    sv_d = !flush && (sv_q ? !out_ready : (acc && !m_load));
    m_d = (m_load && sv_q) ? s_q : (m_load && acc) ? dec : m_q;
    s_d = (acc && !m_load) ? dec : s_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
      mv_q <= 1'b0;
      sv_q <= 1'b0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
      mv_q <= mv_d;
      sv_q <= sv_d;
    end
  end
  assign in_ready = !sv_q;
  assign out_valid = mv_q;
  assign alu_in1 = m_q.alu_in1;
  assign alu_in2 = m_q.alu_in2;
  assign ALUop = m_q.alu_op;
  assign funct = m_q.funct;
  assign invert = m_q.invert;
  assign rd = m_q.rd;
  assign reg_we = m_q.reg_we;
  assign illegal = m_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table-driven decode vectors through a scoreboard, plus skid/flush/reset sequences
module tb_alu_issue_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid, invert, reg_we, illegal;
  logic [31:0] instr = 0, pc = 0, rs1_data = 0, rs2_data = 0, alu_in1, alu_in2;
  logic [2:0] alu_op, funct;
  logic [4:0] rd;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .ALUop(alu_op), .funct(funct),
    .invert(invert), .rd(rd), .reg_we(reg_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  op;
    logic [2:0]  fn;
    logic        inv;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  vec_t vecs[19];
  exp_t sb[$];
  exp_t cur_exp, m_e;
  int total = 0, bad = 0, pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    instr = v.instr;
    pc = v.pc;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
    cur_exp = v.e;
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] i1, input logic [31:0] i2,
                              input logic [2:0] op, input logic [2:0] fn, input logic inv,
                              input logic [4:0] d, input logic we, input logic ill);
    vec_t v;
    v.instr = ins;
    v.pc = p;
    v.rs1 = r1;
    v.rs2 = r2;
    v.e = '{in1: i1, in2: i2, op: op, fn: fn, inv: inv, rd: d, we: we, ill: ill};
    return v;
  endfunction

  task automatic drain_wait(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got out_valid with empty scoreboard, alu_in1=%h", alu_in1);
        end else begin
          m_e = sb.pop_front();
          pops++;
          chk($sformatf("out%0d.alu_in1", pops), alu_in1, m_e.in1);
          chk($sformatf("out%0d.alu_in2", pops), alu_in2, m_e.in2);
          chk($sformatf("out%0d.ALUop", pops), 32'(alu_op), 32'(m_e.op));
          chk($sformatf("out%0d.funct", pops), 32'(funct), 32'(m_e.fn));
          chk($sformatf("out%0d.invert", pops), 32'(invert), 32'(m_e.inv));
          chk($sformatf("out%0d.rd", pops), 32'(rd), 32'(m_e.rd));
          chk($sformatf("out%0d.reg_we", pops), 32'(reg_we), 32'(m_e.we));
          chk($sformatf("out%0d.illegal", pops), 32'(illegal), 32'(m_e.ill));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(32'h002081B3, 32'h100, 32'h5,        32'h7,    32'h5,        32'h7,        3'd0, 3'd0, 1'b0, 5'd3,  1'b1, 1'b0);
    vecs[1]  = mk(32'h402081B3, 32'h100, 32'h5,        32'h7,    32'h5,        32'h7,        3'd5, 3'd0, 1'b1, 5'd3,  1'b1, 1'b0);
    vecs[2]  = mk(32'hFFF00093, 32'h104, 32'h11,       32'h22,   32'h11,       32'hFFFFFFFF, 3'd0, 3'd0, 1'b0, 5'd1,  1'b1, 1'b0);
    vecs[3]  = mk(32'h00812283, 32'h108, 32'h1000,     32'h33,   32'h1000,     32'h8,        3'd1, 3'd0, 1'b0, 5'd5,  1'b1, 1'b0);
    vecs[4]  = mk(32'h00001097, 32'h100, 32'h44,       32'h55,   32'h100,      32'h1000,     3'd3, 3'd0, 1'b0, 5'd1,  1'b1, 1'b0);
    vecs[5]  = mk(32'h00000000, 32'h10C, 32'h66,       32'h77,   32'h0,        32'h0,        3'd0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b1);
    vecs[6]  = mk(32'h4020D233, 32'h110, 32'hF0000000, 32'h4,    32'hF0000000, 32'h4,        3'd0, 3'd5, 1'b1, 5'd4,  1'b1, 1'b0);
    vecs[7]  = mk(32'h4030D213, 32'h114, 32'h80000000, 32'h9,    32'h80000000, 32'h403,      3'd0, 3'd5, 1'b1, 5'd4,  1'b1, 1'b0);
    vecs[8]  = mk(32'h0020A623, 32'h118, 32'h2000,     32'hDEAD, 32'h2000,     32'hC,        3'd1, 3'd0, 1'b0, 5'd12, 1'b0, 1'b0);
    vecs[9]  = mk(32'h00208063, 32'h11C, 32'h1,        32'h2,    32'h1,        32'h2,        3'd5, 3'd0, 1'b1, 5'd0,  1'b0, 1'b0);
    vecs[10] = mk(32'h0020E063, 32'h120, 32'h3,        32'h4,    32'h3,        32'h4,        3'd0, 3'd3, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[11] = mk(32'h0020D063, 32'h124, 32'h5,        32'h6,    32'h5,        32'h6,        3'd0, 3'd2, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[12] = mk(32'hABCDE3B7, 32'h128, 32'h99,       32'h88,   32'h0,        32'hABCDE000, 3'd3, 3'd0, 1'b0, 5'd7,  1'b1, 1'b0);
    vecs[13] = mk(32'h000000EF, 32'h12C, 32'h1,        32'h1,    32'h12C,      32'h4,        3'd3, 3'd0, 1'b0, 5'd1,  1'b1, 1'b0);
    vecs[14] = mk(32'h00008067, 32'h130, 32'h1,        32'h1,    32'h130,      32'h4,        3'd3, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[15] = mk(32'h300092F3, 32'h134, 32'hABC,      32'h1,    32'hABC,      32'h0,        3'd4, 3'd1, 1'b0, 5'd5,  1'b1, 1'b0);
    vecs[16] = mk(32'h3008D2F3, 32'h138, 32'hABC,      32'h1,    32'h11,       32'h0,        3'd4, 3'd5, 1'b0, 5'd5,  1'b1, 1'b0);
    vecs[17] = mk(32'h00208033, 32'h13C, 32'h5,        32'h7,    32'h5,        32'h7,        3'd0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[18] = mk(32'hFFB12093, 32'h140, 32'h7,        32'h8,    32'h7,        32'hFFFFFFFB, 3'd0, 3'd2, 1'b0, 5'd1,  1'b1, 1'b0);

    #2;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.alu_in1", alu_in1, 0);
    chk("rst.alu_in2", alu_in2, 0);
    chk("rst.ALUop", 32'(alu_op), 0);
    chk("rst.reg_we", 32'(reg_we), 0);
    chk("rst.illegal", 32'(illegal), 0);
    tick();
    rst_n = 1;
    tick();

    // pass 0 streams at full rate, pass 1 exercises the skid with random backpressure
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 19; i++) begin
        int n = 0;
        while (!in_ready && n < 50) begin
          in_valid = 0;
          out_ready = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        chk($sformatf("p%0d.v%0d.in_ready", p, i), 32'(in_ready), 1);
        apply(vecs[i]);
        in_valid = 1;
        out_ready = (p == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
      end
      in_valid = 0;
      out_ready = 1;
      drain_wait($sformatf("p%0d.drain", p));
    end
    chk("stream.pops", pops, 38);

    // backpressure: A,B fill M and S, C waits upstream, then all leave in order
    out_ready = 0;
    apply(vecs[0]); in_valid = 1;
    tick();
    chk("bp.a.out_valid", 32'(out_valid), 1);
    chk("bp.a.in_ready", 32'(in_ready), 1);
    apply(vecs[1]);
    tick();
    chk("bp.b.in_ready", 32'(in_ready), 0);
    apply(vecs[3]);
    tick();
    chk("bp.c.in_ready", 32'(in_ready), 0);
    chk("bp.hold.alu_in1", alu_in1, 32'h5);
    tick();
    chk("bp.hold2.ALUop", 32'(alu_op), 0);
    chk("bp.hold2.alu_in2", alu_in2, 32'h7);
    out_ready = 1;
    tick();
    chk("bp.b.out_valid", 32'(out_valid), 1);
    chk("bp.b.ALUop", 32'(alu_op), 5);
    chk("bp.reopen.in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    chk("bp.c.out_valid", 32'(out_valid), 1);
    chk("bp.c.alu_in1", alu_in1, 32'h1000);
    tick();
    chk("bp.end.out_valid", 32'(out_valid), 0);
    drain_wait("bp.drain");

    // flush with both entries full and an instruction presented
    out_ready = 0;
    apply(vecs[4]); in_valid = 1;
    tick();
    apply(vecs[6]);
    tick();
    chk("fl1.full.in_ready", 32'(in_ready), 0);
    apply(vecs[7]); flush = 1;
    tick();
    flush = 0; in_valid = 0;
    chk("fl1.out_valid", 32'(out_valid), 0);
    chk("fl1.in_ready", 32'(in_ready), 1);
    // flush in the same cycle as an accept that would land in S
    apply(vecs[8]); in_valid = 1;
    tick();
    apply(vecs[9]); flush = 1;
    tick();
    flush = 0; in_valid = 0;
    chk("fl2.out_valid", 32'(out_valid), 0);
    chk("fl2.in_ready", 32'(in_ready), 1);
    tick();
    chk("fl2.after.out_valid", 32'(out_valid), 0);

    // asynchronous reset in the middle of backpressure
    out_ready = 0;
    apply(vecs[12]); in_valid = 1;
    tick();
    apply(vecs[13]);
    tick();
    in_valid = 0;
    chk("rst2.full.in_ready", 32'(in_ready), 0);
    rst_n = 0;
    sb.delete();
    #1;
    chk("rst2.out_valid", 32'(out_valid), 0);
    chk("rst2.in_ready", 32'(in_ready), 1);
    chk("rst2.alu_in2", alu_in2, 0);
    chk("rst2.ALUop", 32'(alu_op), 0);
    chk("rst2.rd", 32'(rd), 0);
    chk("rst2.reg_we", 32'(reg_we), 0);
    tick();
    rst_n = 1;
    tick();
    chk("rst2.after.out_valid", 32'(out_valid), 0);
    out_ready = 1;
    apply(vecs[2]); in_valid = 1;
    tick();
    in_valid = 0;
    drain_wait("rst2.drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
